// File: rtl/counter_mod10_checker_if.sv
// Observation bus between a mod-10 up/down counter and its checker.
// The master side drives the observed counter signals; the slave side is the checker.
interface counter_mod10_checker_if #(
   parameter int ERR_CNT_W = 8
);
   logic                 CHK_EN;
   logic                 ERR_CLR;
   logic                 COUNTER_ACTIVE;
   logic                 UP_DOWN;
   logic [3:0]           DATA_IN;
   logic [3:0]           DATA_OUT;
   logic [3:0]           EXP_OUT;
   logic                 CHK_VALID;
   logic                 CHK_ERR;
   logic                 RANGE_ERR;
   logic                 ERR_STICKY;
   logic [ERR_CNT_W-1:0] ERR_COUNT;
   logic [3:0]           FIRST_EXP;
   logic [3:0]           FIRST_ACT;

   modport master (
      output CHK_EN, ERR_CLR, COUNTER_ACTIVE, UP_DOWN, DATA_IN, DATA_OUT,
      input  EXP_OUT, CHK_VALID, CHK_ERR, RANGE_ERR, ERR_STICKY, ERR_COUNT,
             FIRST_EXP, FIRST_ACT
   );

   modport slave (
      input  CHK_EN, ERR_CLR, COUNTER_ACTIVE, UP_DOWN, DATA_IN, DATA_OUT,
      output EXP_OUT, CHK_VALID, CHK_ERR, RANGE_ERR, ERR_STICKY, ERR_COUNT,
             FIRST_EXP, FIRST_ACT
   );
endinterface

// File: rtl/counter_mod10_checker.sv
// Observer for a mod-10 up/down counter: predicts the next count, flags
// mismatches and out-of-range values, and keeps sticky error statistics.
module counter_mod10_checker #(
   parameter int ERR_CNT_W     = 8,
   parameter bit RESYNC_ON_ERR = 1'b1
) (
   input logic                CLK,
   input logic                RESET_0,
   counter_mod10_checker_if.slave mon
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SYNC  = 2'd1,
      ST_TRACK = 2'd2
   } state_t;

   localparam logic [ERR_CNT_W-1:0] CNT_ZERO = {ERR_CNT_W{1'b0}};
   localparam logic [ERR_CNT_W-1:0] CNT_ONE  = ERR_CNT_W'(1'b1);
   localparam logic [ERR_CNT_W-1:0] CNT_MAX  = {ERR_CNT_W{1'b1}};

   // Counter behaviour; an illegal current value is treated as 0.
   function automatic logic [3:0] next_count(
      input logic [3:0] cur,
      input logic       active,
      input logic       up,
      input logic [3:0] load
   );
      logic [3:0] base;
      logic [3:0] result;
      base = (cur > 4'd9) ? 4'd0 : cur;
      if (!active) begin
         result = (load > 4'd9) ? 4'd0 : load;
      end else if (up) begin
         result = (base == 4'd9) ? 4'd0 : base + 4'd1;
      end else begin
         result = (base == 4'd0) ? 4'd9 : base - 4'd1;
      end
      return result;
   endfunction

   state_t                state_r;
   state_t                state_nxt_s;
   logic [3:0]            exp_out_r;
   logic [3:0]            exp_nxt_s;
   logic [3:0]            base_s;
   logic                  cmp_s;
   logic                  mismatch_s;
   logic                  range_s;
   logic                  err_s;
   logic                  chk_err_r;
   logic                  range_err_r;
   logic                  err_sticky_r;
   logic [ERR_CNT_W-1:0]  err_count_r;
   logic [3:0]            first_exp_r;
   logic [3:0]            first_act_r;

   // Error detection for the current edge and the base for the next prediction.
   always_comb begin
      cmp_s      = 1'b0;
      mismatch_s = 1'b0;
      range_s    = 1'b0;
      base_s     = exp_out_r;
      cmp_s      = (state_r == ST_TRACK) && mon.CHK_EN;
      if (cmp_s) begin
         mismatch_s = (mon.DATA_OUT != exp_out_r);
         range_s    = (mon.DATA_OUT > 4'd9);
      end else begin
         mismatch_s = 1'b0;
         range_s    = 1'b0;
      end
      err_s = mismatch_s | range_s;
      if (err_s && RESYNC_ON_ERR) begin
         base_s = range_s ? 4'd0 : mon.DATA_OUT;
      end else begin
         base_s = exp_out_r;
      end
   end

   // Next-state and next-prediction logic.
   always_comb begin
      state_nxt_s = state_r;
      exp_nxt_s   = exp_out_r;
      case (state_r)
         ST_IDLE: begin
            if (mon.CHK_EN) begin
               state_nxt_s = ST_SYNC;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_SYNC: begin
            if (mon.CHK_EN) begin
               exp_nxt_s   = next_count(mon.DATA_OUT, mon.COUNTER_ACTIVE,
                                        mon.UP_DOWN, mon.DATA_IN);
               state_nxt_s = ST_TRACK;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_TRACK: begin
            if (mon.CHK_EN) begin
               exp_nxt_s   = next_count(base_s, mon.COUNTER_ACTIVE,
                                        mon.UP_DOWN, mon.DATA_IN);
               state_nxt_s = ST_TRACK;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
            exp_nxt_s   = exp_out_r;
         end
      endcase
   end

   // State and prediction registers. Reset parks in TRACK; with CHK_EN low the
   // block reports not-valid and drops to IDLE on the first edge, which makes
   // the post-reset state follow CHK_EN without an input-dependent reset value.
   always_ff @(posedge CLK or negedge RESET_0) begin
      if (!RESET_0) begin
         state_r     <= ST_TRACK;
         exp_out_r   <= 4'd0;
         chk_err_r   <= 1'b0;
         range_err_r <= 1'b0;
      end else begin
         state_r     <= state_nxt_s;
         exp_out_r   <= exp_nxt_s;
         chk_err_r   <= err_s;
         range_err_r <= range_s;
      end
   end

   // Error statistics; a clear on the same edge as a new error keeps only the new error.
   always_ff @(posedge CLK or negedge RESET_0) begin
      if (!RESET_0) begin
         err_sticky_r <= 1'b0;
         err_count_r  <= CNT_ZERO;
         first_exp_r  <= 4'd0;
         first_act_r  <= 4'd0;
      end else if (mon.ERR_CLR) begin
         err_sticky_r <= err_s;
         err_count_r  <= err_s ? CNT_ONE : CNT_ZERO;
         first_exp_r  <= err_s ? exp_out_r : 4'd0;
         first_act_r  <= err_s ? mon.DATA_OUT : 4'd0;
      end else if (err_s) begin
         err_sticky_r <= 1'b1;
         if (err_count_r != CNT_MAX) begin
            err_count_r <= err_count_r + CNT_ONE;
         end
         if (!err_sticky_r) begin
            first_exp_r <= exp_out_r;
            first_act_r <= mon.DATA_OUT;
         end
      end
   end

   assign mon.EXP_OUT    = exp_out_r;
   assign mon.CHK_VALID  = (state_r == ST_TRACK) && mon.CHK_EN;
   assign mon.CHK_ERR    = chk_err_r;
   assign mon.RANGE_ERR  = range_err_r;
   assign mon.ERR_STICKY = err_sticky_r;
   assign mon.ERR_COUNT  = err_count_r;
   assign mon.FIRST_EXP  = first_exp_r;
   assign mon.FIRST_ACT  = first_act_r;

endmodule
